// File: rtl/cla_seq_subtractor_if.sv
// Operand/result handshake bundle for cla_seq_subtractor.
// The master drives operands and result acceptance; the slave is the subtractor.
interface cla_seq_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/cla_seq_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit CLA slice per cycle, LSB first.
// Computed as a + ~b + ~bin with the slice carry registered between cycles.
module cla_seq_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla_seq_subtractor_if.slave  bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [IDXW+1:0]  base;
    logic [3:0]       x, y, p, g, s;
    logic [4:0]       c;

    // Shared 4-bit lookahead slice on the current nibble of a and ~b.
    always_comb begin
        base = {idx_q, 2'b00};
        x    = a_q[base +: 4];
        y    = ~b_q[base +: 4];
        p    = x ^ y;
        g    = x & y;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = ~bus.bin;
                    idx_d   = '0;
                    diff_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[base +: 4] = s;
                carry_d           = c[4];
                idx_d             = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    bout_d  = ~c[4];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (s[3] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_subtractor.sv
// Self-checking bench for cla_seq_subtractor (WIDTH=16): directed cases, backpressure,
// mid-operation reset, then randomized operations against an arithmetic reference.
module tb_cla_seq_subtractor;
    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cla_seq_subtractor_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned borrow from a 17-bit difference, overflow from signed range.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         output logic [15:0] d, output logic bo, output logic ov);
        logic [16:0] full;
        int          r;
        full = {1'b0, a} - {1'b0, b} - 17'(bin);
        d    = full[15:0];
        bo   = full[16];
        r    = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ov   = (r > 32767) || (r < -32768);
    endtask

    task automatic check_result(input string tag, input logic [15:0] ed,
                                input logic eb, input logic eo);
        chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(0));
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input int hold, input bit noisy);
        logic [15:0] ed;
        logic        eb, eo;
        int          k;
        model(a, b, bin, ed, eb, eo);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        chk("in_ready_idle", 32'(bus.in_ready), 32'(1));
        tick;
        bus.in_valid  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.a         = 16'($urandom);
        bus.b         = 16'($urandom);
        bus.bin       = 1'($urandom_range(0, 1));
        bus.out_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 4 * NSLICE) begin
            chk("in_ready_run", 32'(bus.in_ready), 32'(0));
            tick;
            k++;
            if (noisy) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.a         = 16'($urandom);
                bus.b         = 16'($urandom);
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
        chk("latency", 32'(k), 32'(NSLICE));
        check_result("result", ed, eb, eo);
        if (hold > 0) bus.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.bin      = 1'($urandom_range(0, 1));
            tick;
            chk("hold_out_valid", 32'(bus.out_valid), 32'(1));
            check_result("hold", ed, eb, eo);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        tick;
        chk("release_out_valid", 32'(bus.out_valid), 32'(0));
        chk("release_in_ready", 32'(bus.in_ready), 32'(1));
        bus.out_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        rst_n         = 1'b0;
        tick;
        tick;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("rst_diff", 32'(bus.diff), 32'(0));
        chk("rst_bout", 32'(bus.bout), 32'(0));
        chk("rst_ovf", 32'(bus.ovf), 32'(0));
        rst_n = 1'b1;
        tick;

        run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0);
        run_op(16'h0000, 16'h8000, 1'b1, 0, 1'b0);

        // Backpressure with in_valid pulses while the result is held.
        run_op(16'h4321, 16'h1234, 1'b0, 10, 1'b0);

        // Leave bout=ovf=1 behind, then reset two cycles into the next operation.
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
        bus.a        = 16'h0000;
        bus.b        = 16'h0001;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("midrst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("midrst_diff", 32'(bus.diff), 32'(0));
        chk("midrst_bout", 32'(bus.bout), 32'(0));
        chk("midrst_ovf", 32'(bus.ovf), 32'(0));
        tick;
        rst_n = 1'b1;
        tick;
        run_op(16'h00FF, 16'h0F0F, 1'b0, 0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) begin
                bus.in_valid = 1'b0;
                tick;
            end
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
